// File: rtl/uart_core_param.sv
// Parametrised UART transceiver on the system clock, sharing one baud tick enable.
// Optional `UART_LOOPBACK_EN adds a loopback input that routes TX into RX.
module uart_core_param #(
   parameter int CLK_FREQ   = 100000000,
   parameter int BAUD       = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 txd,
   input  logic                 rxd,
`ifdef UART_LOOPBACK_EN
   input  logic                 loopback,
`endif
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err
);

   localparam int DIV   = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int OS_W  = $clog2(OVERSAMPLE);

   localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(DIV - 1);
   localparam logic [OS_W-1:0]  OS_MAX    = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0]  OS_MID    = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT
   } rx_state_e;

   function automatic logic par_of(input logic [DATA_BITS-1:0] d);
      return (PARITY == 1) ? ~^d : ^d;
   endfunction

   // ---------------- baud tick ----------------
   logic [DIV_W-1:0] div_q, div_d;
   logic             tick;

   always_comb begin
      tick  = (div_q == DIV_MAX);
      div_d = tick ? '0 : div_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) div_q <= '0;
      else      div_q <= div_d;
   end

   // ---------------- transmitter ----------------
   tx_state_e            tx_state_q, tx_state_d;
   logic [OS_W-1:0]      tx_cnt_q, tx_cnt_d;
   logic [3:0]           tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
   logic                 tx_par_q, tx_par_d;
   logic                 tx_line_q, tx_line_d;
   logic                 tx_bit_end;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      tx_par_d   = tx_par_q;
      tx_bit_end = tick && (tx_cnt_q == OS_MAX);
      if (tick) tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
      unique case (tx_state_q)
         TX_IDLE: begin
            if (tx_valid) begin
               tx_state_d = TX_START;
               tx_sh_d    = tx_data;
               tx_par_d   = par_of(tx_data);
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
            end
         end
         TX_START: begin
            if (tx_bit_end) tx_state_d = TX_DATA;
         end
         TX_DATA: begin
            if (tx_bit_end) begin
               tx_sh_d = tx_sh_q >> 1;
               if (tx_bit_q == LAST_DATA) begin
                  tx_bit_d   = '0;
                  tx_state_d = (PARITY != 0) ? TX_PAR : TX_STOP;
               end else begin
                  tx_bit_d = tx_bit_q + 1'b1;
               end
            end
         end
         TX_PAR: begin
            if (tx_bit_end) begin
               tx_bit_d   = '0;
               tx_state_d = TX_STOP;
            end
         end
         TX_STOP: begin
            if (tx_bit_end) begin
               if (tx_bit_q == LAST_STOP) tx_state_d = TX_IDLE;
               else                       tx_bit_d   = tx_bit_q + 1'b1;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
      // Line level is registered from the next state so txd never glitches.
      unique case (tx_state_d)
         TX_START: tx_line_d = 1'b0;
         TX_DATA:  tx_line_d = tx_sh_d[0];
         TX_PAR:   tx_line_d = tx_par_d;
         default:  tx_line_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_sh_q    <= '0;
         tx_par_q   <= 1'b0;
         tx_line_q  <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_sh_q    <= tx_sh_d;
         tx_par_q   <= tx_par_d;
         tx_line_q  <= tx_line_d;
      end
   end

   assign tx_ready = (tx_state_q == TX_IDLE);

   // ---------------- line routing ----------------
   logic rx_in;

`ifdef UART_LOOPBACK_EN
   assign rx_in = loopback ? tx_line_q : rxd;
   assign txd   = loopback ? 1'b1 : tx_line_q;
`else
   assign rx_in = rxd;
   assign txd   = tx_line_q;
`endif

   // ---------------- receiver ----------------
   logic rx_s1_q, rx_s2_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_s1_q <= 1'b1;
         rx_s2_q <= 1'b1;
      end else begin
         rx_s1_q <= rx_in;
         rx_s2_q <= rx_s1_q;
      end
   end

   rx_state_e            rx_state_q, rx_state_d;
   logic [OS_W-1:0]      rx_cnt_q, rx_cnt_d;
   logic [3:0]           rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
   logic                 rx_pe_q, rx_pe_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 rx_perr_q, rx_perr_d;
   logic                 rx_ferr_q, rx_ferr_d;
   logic                 rx_sample;

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_pe_d    = rx_pe_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rx_perr_d  = rx_perr_q;
      rx_ferr_d  = rx_ferr_q;
      rx_sample  = tick && (rx_cnt_q == OS_MAX);
      if (tick) rx_cnt_d = rx_sample ? '0 : rx_cnt_q + 1'b1;
      unique case (rx_state_q)
         RX_IDLE: begin
            if (!rx_s2_q) begin
               rx_state_d = RX_START;
               rx_cnt_d   = '0;
            end
         end
         RX_START: begin
            // Mid start bit re-aligns the counter so later samples land mid-bit.
            if (tick && (rx_cnt_q == OS_MID)) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_pe_d    = 1'b0;
               rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_sample) begin
               rx_sh_d = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
               if (rx_bit_q == LAST_DATA) begin
                  rx_state_d = (PARITY != 0) ? RX_PAR : RX_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 1'b1;
               end
            end
         end
         RX_PAR: begin
            if (rx_sample) begin
               rx_pe_d    = (rx_s2_q != par_of(rx_sh_q));
               rx_state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_sample) begin
               rx_valid_d = 1'b1;
               rx_data_d  = rx_sh_q;
               rx_perr_d  = rx_pe_q;
               rx_ferr_d  = !rx_s2_q;
               rx_state_d = rx_s2_q ? RX_IDLE : RX_WAIT;
            end
         end
         RX_WAIT: begin
            if (rx_s2_q) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_pe_q    <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_perr_q  <= 1'b0;
         rx_ferr_q  <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
         rx_pe_q    <= rx_pe_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_perr_q  <= rx_perr_d;
         rx_ferr_q  <= rx_ferr_d;
      end
   end

   assign rx_data       = rx_data_q;
   assign rx_valid      = rx_valid_q;
   assign rx_parity_err = rx_perr_q;
   assign rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param: an 8N1 and an 8E1 instance at 10 kbaud on a 1.6 MHz clock.
`timescale 1ns/1ps
module tb_uart_core_param;

   localparam int CF  = 1600000;
   localparam int BR  = 10000;
   localparam int OS  = 16;
   localparam int BIT = 160;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] tx_data = '0;
   logic       tx_valid_n = 1'b0, tx_valid_e = 1'b0;
   logic       tx_ready_n, tx_ready_e, txd_n, txd_e;
   logic       rxd_n = 1'b1, rxd_e = 1'b1;
   logic [7:0] rx_data_n, rx_data_e;
   logic       rx_valid_n, rx_valid_e, pe_n, pe_e, fe_n, fe_e;
`ifdef UART_LOOPBACK_EN
   logic       lb_n = 1'b0;
   logic       lb_e = 1'b0;
`endif

   uart_core_param #(
      .CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(8),
      .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(OS)
   ) u_n (
      .clk(clk), .rst(rst),
      .tx_data(tx_data), .tx_valid(tx_valid_n),
      .tx_ready(tx_ready_n), .txd(txd_n), .rxd(rxd_n),
`ifdef UART_LOOPBACK_EN
      .loopback(lb_n),
`endif
      .rx_data(rx_data_n), .rx_valid(rx_valid_n),
      .rx_parity_err(pe_n), .rx_frame_err(fe_n)
   );

   uart_core_param #(
      .CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(8),
      .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(OS)
   ) u_e (
      .clk(clk), .rst(rst),
      .tx_data(tx_data), .tx_valid(tx_valid_e),
      .tx_ready(tx_ready_e), .txd(txd_e), .rxd(rxd_e),
`ifdef UART_LOOPBACK_EN
      .loopback(lb_e),
`endif
      .rx_data(rx_data_e), .rx_valid(rx_valid_e),
      .rx_parity_err(pe_e), .rx_frame_err(fe_e)
   );

   int checks = 0;
   int failures = 0;
   int vcnt_n = 0;
   int vcnt_e = 0;
   int sel = 0;

   logic txd_m, rdy_m;
   assign txd_m = (sel != 0) ? txd_e : txd_n;
   assign rdy_m = (sel != 0) ? tx_ready_e : tx_ready_n;

   always @(negedge clk) begin
      if (rx_valid_n) vcnt_n++;
      if (rx_valid_e) vcnt_e++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_range(input string nm, input int v, input int lo, input int hi);
      checks++;
      if (v < lo || v > hi) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d..%0d", nm, v, lo, hi);
      end
   endtask

   // Reference frame: start 0, data LSB first, even parity if s, then stop 1s.
   function automatic int frame_len(input int s);
      return (s != 0) ? 11 : 10;
   endfunction

   function automatic logic [15:0] frame_bits(input int s, input logic [7:0] d);
      logic [15:0] f;
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1+i] = d[i];
      if (s != 0) f[9] = ^d;
      return f;
   endfunction

   task automatic tx_frame(input int s, input logic [7:0] d, input string nm);
      logic        tr[$];
      int          len, s0, nb, a, b;
      logic [15:0] exp_f, got;
      nb = frame_len(s);
      exp_f = frame_bits(s, d);
      sel = s;
      @(negedge clk);
      tx_data = d;
      if (s != 0) tx_valid_e = 1'b1;
      else        tx_valid_n = 1'b1;
      @(negedge clk);
      tx_valid_n = 1'b0;
      tx_valid_e = 1'b0;
      len = 0;
      while (rdy_m == 1'b0 && len < 3000) begin
         tr.push_back(txd_m);
         len++;
         @(negedge clk);
      end
      chk({nm, "_ready_back"}, {31'd0, rdy_m}, 32'd1);
      chk({nm, "_idle_txd"}, {31'd0, txd_m}, 32'd1);
      chk_range({nm, "_busy_len"}, len, 1585, 1600 + (nb - 10) * BIT);
      s0 = len - (nb - 1) * BIT;
      chk_range({nm, "_start_len"}, s0, 151, 160);
      if (s0 >= 151 && s0 <= 160) begin
         got = '1;
         for (int k = 0; k < nb; k++) begin
            a = (k == 0) ? 0 : s0 + (k - 1) * BIT + 5;
            b = s0 + k * BIT - 6;
            got[k] = (tr[a] === tr[b]) ? tr[a] : ~exp_f[k];
         end
         chk({nm, "_bits"}, {16'd0, got}, {16'd0, exp_f});
      end
   endtask

   task automatic rx_send(input int s, input logic [7:0] d, input bit flip,
                          input bit stop, input int tail_low);
      logic [15:0] f;
      int nb;
      f = frame_bits(s, d);
      nb = frame_len(s);
      if (s != 0 && flip) f[9] = ~f[9];
      f[nb-1] = stop;
      @(negedge clk);
      for (int k = 0; k < nb; k++) begin
         if (s != 0) rxd_e = f[k];
         else        rxd_n = f[k];
         repeat (BIT) @(negedge clk);
      end
      if (tail_low > 0) begin
         if (s != 0) rxd_e = 1'b0;
         else        rxd_n = 1'b0;
         repeat (tail_low) @(negedge clk);
      end
      rxd_e = 1'b1;
      rxd_n = 1'b1;
   endtask

   task automatic rx_expect(input int s, input int c0, input string nm,
                            input logic [7:0] ed, input bit epe, input bit efe);
      int c;
      repeat (40) @(negedge clk);
      c = (s != 0) ? vcnt_e : vcnt_n;
      chk({nm, "_pulses"}, c - c0, 32'd1);
      chk({nm, "_data"}, {24'd0, (s != 0) ? rx_data_e : rx_data_n}, {24'd0, ed});
      chk({nm, "_perr"}, {31'd0, (s != 0) ? pe_e : pe_n}, {31'd0, epe});
      chk({nm, "_ferr"}, {31'd0, (s != 0) ? fe_e : fe_n}, {31'd0, efe});
   endtask

   typedef struct {
      int         s;
      logic [7:0] d;
      bit         flip;
      bit         stop;
      logic [7:0] exp_d;
      bit         exp_pe;
      bit         exp_fe;
      string      nm;
   } rxvec_t;

   rxvec_t vec[7];

   initial begin
      #950000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          c0, n;
      bit          stayed_high;
      logic [7:0]  d;
      int          s;
      bit          flip, stop, epar;

      vec[0] = '{0, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, "rx_8n1_3c"};
      vec[1] = '{1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0, "rx_8e1_07_badpar"};
      vec[2] = '{1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0, "rx_8e1_07_okpar"};
      vec[3] = '{1, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, "rx_8e1_a5_badstop"};
      vec[4] = '{0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, "rx_8n1_ff"};
      vec[5] = '{0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "rx_8n1_00_badstop"};
      vec[6] = '{1, 8'h80, 1'b1, 1'b0, 8'h80, 1'b1, 1'b1, "rx_8e1_80_bothbad"};

      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_n", {19'd0, txd_n, tx_ready_n, rx_valid_n, pe_n, fe_n, rx_data_n},
          {19'd0, 5'b11000, 8'h00});
      chk("reset_e", {19'd0, txd_e, tx_ready_e, rx_valid_e, pe_e, fe_e, rx_data_e},
          {19'd0, 5'b11000, 8'h00});
      rst = 1'b1;
      repeat (5) @(negedge clk);

      tx_frame(0, 8'hA5, "tx_8n1_a5");
      tx_frame(1, 8'h07, "tx_8e1_07");

      for (int i = 0; i < 7; i++) begin
         c0 = (vec[i].s != 0) ? vcnt_e : vcnt_n;
         rx_send(vec[i].s, vec[i].d, vec[i].flip, vec[i].stop, 0);
         rx_expect(vec[i].s, c0, vec[i].nm, vec[i].exp_d, vec[i].exp_pe, vec[i].exp_fe);
         repeat (100) @(negedge clk);
      end

      // Short glitch must be rejected as a false start.
      c0 = vcnt_n;
      rxd_n = 1'b0;
      repeat (40) @(negedge clk);
      rxd_n = 1'b1;
      repeat (400) @(negedge clk);
      chk("glitch_no_valid", vcnt_n - c0, 32'd0);

      // Framing error followed by a long break: one pulse only.
      c0 = vcnt_n;
      rx_send(0, 8'h55, 1'b0, 1'b0, 2000);
      chk("break_pulses", vcnt_n - c0, 32'd1);
      chk("break_data", {24'd0, rx_data_n}, 32'h55);
      chk("break_ferr", {31'd0, fe_n}, 32'd1);
      repeat (400) @(negedge clk);
      chk("break_release_quiet", vcnt_n - c0, 32'd1);
      c0 = vcnt_n;
      rx_send(0, 8'h3C, 1'b0, 1'b1, 0);
      rx_expect(0, c0, "after_break", 8'h3C, 1'b0, 1'b0);

      // Reset in the middle of data bit 3 (a 0 bit of 0xA5).
      sel = 0;
      @(negedge clk);
      tx_data = 8'hA5;
      tx_valid_n = 1'b1;
      @(negedge clk);
      tx_valid_n = 1'b0;
      repeat (155 + 3 * BIT + 80 - 1) @(negedge clk);
      chk("mid_bit3_txd", {31'd0, txd_n}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_tx_txd", {31'd0, txd_n}, 32'd1);
      chk("rst_mid_tx_ready", {31'd0, tx_ready_n}, 32'd1);
      chk("rst_mid_tx_rxdata", {24'd0, rx_data_n}, 32'd0);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      tx_frame(0, 8'h12, "tx_after_reset");

      for (int i = 0; i < 4; i++) begin
         s = int'($urandom_range(0, 1));
         d = 8'($urandom);
         tx_frame(s, d, $sformatf("tx_rand%0d", i));
      end

      for (int i = 0; i < 6; i++) begin
         s    = int'($urandom_range(0, 1));
         d    = 8'($urandom);
         flip = (s != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         stop = ($urandom_range(0, 3) != 0);
         epar = ^d;
         c0 = (s != 0) ? vcnt_e : vcnt_n;
         rx_send(s, d, flip, stop, 0);
         rx_expect(s, c0, $sformatf("rx_rand%0d", i), d,
                   (s != 0) && ((epar ^ flip) != epar), !stop);
         repeat (100) @(negedge clk);
      end

`ifdef UART_LOOPBACK_EN
      lb_n = 1'b1;
      repeat (5) @(negedge clk);
      c0 = vcnt_n;
      stayed_high = 1'b1;
      tx_data = 8'h9C;
      tx_valid_n = 1'b1;
      @(negedge clk);
      tx_valid_n = 1'b0;
      n = 0;
      while (tx_ready_n == 1'b0 && n < 3000) begin
         if (txd_n !== 1'b1) stayed_high = 1'b0;
         n++;
         @(negedge clk);
      end
      repeat (5) @(negedge clk);
      chk("lb_txd_high", {31'd0, stayed_high}, 32'd1);
      chk("lb_busy", {31'd0, tx_ready_n}, 32'd1);
      chk("lb_pulses", vcnt_n - c0, 32'd1);
      chk("lb_data", {24'd0, rx_data_n}, 32'h9C);
      lb_n = 1'b0;
      repeat (20) @(negedge clk);
`else
      n = 0;
      stayed_high = 1'b1;
      if (n != 0) stayed_high = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
- Parametrised UART transceiver; successor to the fixed 8-bit, 9600-baud TX/RX pair and its divided-clock generator.
- Runs entirely on the system clock, using single-cycle baud tick enables instead of derived clocks.
- Configurable data width, parity mode, stop bits and oversampling; adds parity/framing error reporting and a valid/ready TX handshake.
- Sits between board-level rxd/txd pins and the command/status logic of the car controller.

Parameters:
- CLK_FREQ, 100000000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- DATA_BITS, 8: data bits per frame, 5..9.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: TX stop bits, 1 or 2. RX checks only the first.
- OVERSAMPLE, 16: ticks per bit; even value, at least 8.

Ports:
- clk  in  1  system clock, the only clock in the block.
- rst  in  1  reset; synchronous, active-low (0 = reset, sampled on rising clk).
- tx_data  in  DATA_BITS  word to transmit.
- tx_valid  in  1  transmit request.
- tx_ready  out  1  TX idle; accepts tx_data when tx_valid & tx_ready.
- txd  out  1  serial output, idle high.
- rxd  in  1  serial input, asynchronous.
- rx_data  out  DATA_BITS  last received word; held until the next frame completes.
- rx_valid  out  1  one-cycle pulse per completed frame.
- rx_parity_err  out  1  parity mismatch for the current rx_valid frame.
- rx_frame_err  out  1  first stop bit sampled low for the current frame.

Behaviour:
- Reset (rst=0 at posedge): txd=1, tx_ready=1, rx_valid=0, rx_data=0, both error flags 0.
  - Both FSMs go to IDLE and the tick counters clear.
  - Reset mid-frame aborts the frame; txd=1 on the first cycle after the reset edge.
- Tick generator:
  - DIV = (CLK_FREQ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE), i.e. rounded to nearest.
  - Counter runs 0..DIV-1 and pulses tick for one clk at DIV-1. Free-running; shared by TX and RX.
- TX FSM, states IDLE, START, DATA, PARITY, STOP:
  - IDLE: tx_ready=1. On a handshake, latch tx_data and clear the TX tick counter. txd=0 (START) from the next cycle, and tx_ready=0.
  - Bit timing: each bit lasts OVERSAMPLE ticks. The first bit may be up to one tick shorter because of tick phase.
  - DATA: LSB first.
  - PARITY (skipped when PARITY=0): bit = XOR of data bits; inverted for odd parity.
  - STOP: txd=1 for STOP_BITS bit periods, then IDLE with tx_ready=1.
  - tx_valid while tx_ready=0 is ignored; no queueing.
  - Back-to-back frames: a handshake in the cycle tx_ready returns high starts the next START immediately.
- RX input: rxd passes through a 2-flop synchroniser (reset value 1). Only rxd_s is used.
- RX FSM, states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH:
  - IDLE: rxd_s=0 → START; clear the sample counter.
  - START: at tick count OVERSAMPLE/2-1 (mid-bit), if rxd_s=1 it was a false start → IDLE. Otherwise → DATA.
  - DATA: sample at mid-bit every OVERSAMPLE ticks, shifting LSB first. After DATA_BITS samples → PARITY, or STOP when PARITY=0.
  - PARITY: sample and compare against the expected parity.
  - STOP: sample mid-bit. Next cycle: rx_valid=1 and rx_data updated. rx_parity_err and rx_frame_err are registered together with rx_data and hold until the next rx_valid.
    - Stop bit 1 → IDLE.
    - Stop bit 0 → WAIT_HIGH, which stays until rxd_s=1, so a break cannot retrigger.
  - rx_valid latency: 1 clk after the stop-bit mid sample.
  - Errors never suppress rx_valid; the data is delivered as received.
- TX and RX are independent; simultaneous activity is allowed.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- Defined:
  - Adds input port loopback (1 bit) after rxd.
  - When loopback=1, the RX synchroniser input is the internal TX serial signal and external txd is forced to 1.
  - Changing loopback mid-frame is permitted; the bench must tolerate a corrupted frame.
- Undefined: no loopback port; RX always uses rxd.

Test Plan:
- Common setup: CLK_FREQ=1600000, BAUD=10000, OVERSAMPLE=16 → DIV=10, bit = 160 clk.
- 8N1 TX 0xA5 → txd = 0,1,0,1,0,0,1,0,1,1, each bit 160±10 clk; tx_ready low about 1600 clk, then high.
- 8N1 RX: bench drives frame 0x3C on rxd → exactly one rx_valid pulse; rx_data=0x3C; both error flags 0.
- PARITY=2:
  - TX 0x07 → parity bit 1.
  - RX frame 0x07 with parity bit 0 → rx_valid with rx_parity_err=1 and rx_data=0x07.
- Glitch and break:
  - rxd low for 40 clk → no rx_valid.
  - Frame 0x55 with stop bit 0 followed by 2000 clk of low → one rx_valid with rx_frame_err=1, then no further rx_valid until rxd returns high.
- Reset mid-TX: rst=0 during data bit 3 → txd=1 and tx_ready=1 on the next cycle; a new 0x12 sends cleanly afterwards.
- With UART_LOOPBACK_EN and loopback=1: TX 0x9C → rx_valid with rx_data=0x9C; external txd stays 1 throughout.
